// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP link supervisor: FSM state encoding,
// retry counter width and a small constant helper for sizing counters.
package sfp_pkg;

  // Width of the failed-attempt counter presented on retry_count.
  localparam int RETRY_W = 4;

  // Link supervisor states.
  typedef enum logic [2:0] {
    ST_RESET_PHY  = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_SYNC  = 3'd2,
    ST_LINK_UP    = 3'd3,
    ST_FAULT      = 3'd4
  } link_state_t;

  // Larger of two integers, used to size the shared timer and counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
// Both stages reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage shift to resolve metastability on the incoming level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both stages sample their inputs
      // before either updates, so the chain really is two flops deep.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sfp_link_monitor.sv
// Link-level supervisor for the SFP transceiver path. Drives the PHY reset
// sequencer, waits for ready and word-alignment sync, declares link-up,
// detects loss of link and retries; latches a fault after MAX_RETRIES
// failed bring-up attempts.
// Optional feature: define SFP_LINK_MON_STATS_EN to enable the saturating
// link_drops counter; otherwise link_drops is tied to zero.
module sfp_link_monitor
  import sfp_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int READY_TIMEOUT = 125000,
  parameter int SYNC_TIMEOUT  = 125000,
  parameter int LOCK_CYCLES   = 8,
  parameter int LOSS_CYCLES   = 64,
  parameter int MAX_RETRIES   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_ready,
  input  logic               rx_ready,
  input  logic               rx_syncstatus,
  input  logic               sfp_los,
  output logic               phy_reset,
  output logic               link_up,
  output logic               link_fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [15:0]        link_drops
);

  // One width covers every timer/counter limit so none of them can wrap.
  localparam int MAX_PARAM = max2(max2(max2(RESET_CYCLES, READY_TIMEOUT),
                                       max2(SYNC_TIMEOUT, LOCK_CYCLES)),
                                  LOSS_CYCLES);
  localparam int CNT_W = $clog2(MAX_PARAM + 1);

  localparam logic [CNT_W-1:0]   RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   READY_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SYNC_LAST  = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOSS_LAST  = CNT_W'(LOSS_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  link_state_t        state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               phy_reset_q, phy_reset_d;
  logic               link_up_q, link_up_d;
  logic               link_fault_q, link_fault_d;
  logic               fail;
  logic               los_s;

  sync_2ff u_los_sync (
    .clk (clk),
    .rst (reset),
    .d   (sfp_los),
    .q   (los_s)
  );

  // Next-state, timer, sync/loss counter and retry bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      ST_RESET_PHY: begin
        // LOS holds the timer at zero, which holds the PHY in reset.
        if (los_s) begin
          timer_d = '0;
        end else if (timer_q == RESET_LAST) begin
          state_d = ST_WAIT_READY;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WAIT_READY: begin
        if (los_s) begin
          state_d = ST_RESET_PHY;
        end else if (tx_ready && rx_ready) begin
          state_d = ST_WAIT_SYNC;
        end else if (timer_q == READY_LAST) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ST_WAIT_SYNC: begin
        if (los_s) begin
          state_d = ST_RESET_PHY;
        end else if (!rx_ready) begin
          fail = 1'b1;
        end else if (rx_syncstatus && (cnt_q == LOCK_LAST)) begin
          state_d = ST_LINK_UP;
          retry_d = '0;
        end else if (timer_q == SYNC_LAST) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          cnt_d   = rx_syncstatus ? (cnt_q + 1'b1) : '0;
        end
      end

      ST_LINK_UP: begin
        // Loss of link restarts bring-up without counting as a retry.
        if (los_s || !rx_ready) begin
          state_d = ST_RESET_PHY;
        end else if (!rx_syncstatus && (cnt_q == LOSS_LAST)) begin
          state_d = ST_RESET_PHY;
        end else begin
          cnt_d = rx_syncstatus ? '0 : (cnt_q + 1'b1);
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_RESET_PHY;
      end
    endcase

    if (fail) begin
      retry_d = retry_q + 1'b1;
      state_d = (retry_d == RETRY_MAX) ? ST_FAULT : ST_RESET_PHY;
    end

    // Each state starts with a fresh timer and counter.
    if (state_d != state_q) begin
      timer_d = '0;
      cnt_d   = '0;
    end

    phy_reset_d  = (state_d == ST_RESET_PHY) || (state_d == ST_FAULT);
    link_up_d    = (state_d == ST_LINK_UP);
    link_fault_d = (state_d == ST_FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RESET_PHY;
      timer_q      <= '0;
      cnt_q        <= '0;
      retry_q      <= '0;
      phy_reset_q  <= 1'b1;
      link_up_q    <= 1'b0;
      link_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      phy_reset_q  <= phy_reset_d;
      link_up_q    <= link_up_d;
      link_fault_q <= link_fault_d;
    end
  end

  assign phy_reset   = phy_reset_q;
  assign link_up     = link_up_q;
  assign link_fault  = link_fault_q;
  assign retry_count = retry_q;

`ifdef SFP_LINK_MON_STATS_EN
  logic [15:0] drops_q, drops_d;

  // Count every exit from LINK_UP, saturating at all-ones.
  always_comb begin
    drops_d = drops_q;
    if ((state_q == ST_LINK_UP) && (state_d == ST_RESET_PHY) &&
        (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drops_q <= 16'd0;
    end else begin
      drops_q <= drops_d;
    end
  end

  assign link_drops = drops_q;
`else
  assign link_drops = 16'd0;
`endif

endmodule

// File: tb/tb_sfp_link_monitor.sv
// Directed bench for sfp_link_monitor with small parameters: a table of
// {inputs, cycles, expected outputs} for bring-up and sync-glitch handling,
// then hand-written sequences for retries, fault, LOS, rx_ready drop and
// asynchronous reset.
module tb_sfp_link_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_ready;
  logic        rx_ready;
  logic        rx_syncstatus;
  logic        sfp_los;
  logic        phy_reset;
  logic        link_up;
  logic        link_fault;
  logic [3:0]  retry_count;
  logic [15:0] link_drops;

  int n_vec  = 0;
  int n_fail = 0;

`ifdef SFP_LINK_MON_STATS_EN
  localparam int DROP_INC = 1;
`else
  localparam int DROP_INC = 0;
`endif

  typedef struct {
    logic        tx;
    logic        rx;
    logic        sync;
    logic        los;
    int          cycles;
    logic        phy;
    logic        up;
    logic        flt;
    logic [3:0]  retry;
    logic [15:0] drops;
  } vec_t;

  vec_t vecs[10];

  sfp_link_monitor #(
    .RESET_CYCLES  (4),
    .READY_TIMEOUT (100),
    .SYNC_TIMEOUT  (100),
    .LOCK_CYCLES   (8),
    .LOSS_CYCLES   (16),
    .MAX_RETRIES   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_ready      (tx_ready),
    .rx_ready      (rx_ready),
    .rx_syncstatus (rx_syncstatus),
    .sfp_los       (sfp_los),
    .phy_reset     (phy_reset),
    .link_up       (link_up),
    .link_fault    (link_fault),
    .retry_count   (retry_count),
    .link_drops    (link_drops)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic phy, input logic up,
                            input logic flt, input logic [3:0] rc);
    check({name, ".phy_reset"},   32'(phy_reset),   32'(phy));
    check({name, ".link_up"},     32'(link_up),     32'(up));
    check({name, ".link_fault"},  32'(link_fault),  32'(flt));
    check({name, ".retry_count"}, 32'(retry_count), 32'(rc));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges with idle inputs, release just after an edge.
  task automatic do_reset();
    reset         = 1'b1;
    tx_ready      = 1'b0;
    rx_ready      = 1'b0;
    rx_syncstatus = 1'b0;
    sfp_los       = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    // Nominal bring-up, then sync glitch shorter and equal to LOSS_CYCLES.
    //            tx    rx    sync  los  cyc  phy   up    flt   retry drops
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 4'd0, 16'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 4'd0, 16'd0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b0, 4'd0, 16'd0};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd0, 16'(DROP_INC)};

    // ---- Reset values, then table-driven bring-up and glitch handling ----
    reset = 1'b1;
    tx_ready = 1'b0; rx_ready = 1'b0; rx_syncstatus = 1'b0; sfp_los = 1'b0;
    #1;
    check_outs("reset", 1'b1, 1'b0, 1'b0, 4'd0);
    check("reset.link_drops", 32'(link_drops), 32'd0);
    tick(2);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tx_ready      = vecs[i].tx;
      rx_ready      = vecs[i].rx;
      rx_syncstatus = vecs[i].sync;
      sfp_los       = vecs[i].los;
      tick(vecs[i].cycles);
      check_outs($sformatf("vec%0d", i), vecs[i].phy, vecs[i].up, vecs[i].flt, vecs[i].retry);
      check($sformatf("vec%0d.link_drops", i), 32'(link_drops), 32'(vecs[i].drops));
    end

    // ---- Re-link after the glitch, then a one-cycle rx_ready drop ----
    rx_syncstatus = 1'b1;
    tick(12);
    check("relink.before", 32'(link_up), 32'd0);
    tick(1);
    check_outs("relink", 1'b0, 1'b1, 1'b0, 4'd0);
    rx_ready = 1'b0;
    tick(1);
    check_outs("rxdrop", 1'b1, 1'b0, 1'b0, 4'd0);
    check("rxdrop.link_drops", 32'(link_drops), 32'(2 * DROP_INC));
    rx_ready = 1'b1;
    tick(12);
    check("rxdrop.relink_before", 32'(link_up), 32'd0);
    tick(1);
    check("rxdrop.relink", 32'(link_up), 32'd1);

    // ---- Ready never arrives: retries every 104 cycles, then FAULT ----
    do_reset();
    tick(103);
    check_outs("noready.t103", 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    check_outs("noready.t104", 1'b1, 1'b0, 1'b0, 4'd1);
    tick(103);
    check_outs("noready.t207", 1'b0, 1'b0, 1'b0, 4'd1);
    tick(1);
    check_outs("noready.t208", 1'b1, 1'b0, 1'b0, 4'd2);
    tick(103);
    check_outs("noready.t311", 1'b0, 1'b0, 1'b0, 4'd2);
    tick(1);
    check_outs("noready.fault", 1'b1, 1'b0, 1'b1, 4'd3);
    tick(200);
    check_outs("noready.fault_hold", 1'b1, 1'b0, 1'b1, 4'd3);
    #2;
    reset = 1'b1;
    #1;
    check_outs("fault.async_reset", 1'b1, 1'b0, 1'b0, 4'd0);

    // ---- Two sync timeouts, LOS during WAIT_SYNC, then mid-op reset ----
    do_reset();
    tx_ready = 1'b1;
    rx_ready = 1'b1;
    tick(104);
    check_outs("synctmo.t104", 1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    check_outs("synctmo.t105", 1'b1, 1'b0, 1'b0, 4'd1);
    tick(104);
    check_outs("synctmo.t209", 1'b0, 1'b0, 1'b0, 4'd1);
    tick(1);
    check_outs("synctmo.t210", 1'b1, 1'b0, 1'b0, 4'd2);
    tick(10);
    check_outs("los.pre", 1'b0, 1'b0, 1'b0, 4'd2);
    sfp_los = 1'b1;
    tick(2);
    check("los.sync_delay", 32'(phy_reset), 32'd0);
    tick(1);
    check_outs("los.react", 1'b1, 1'b0, 1'b0, 4'd2);
    tick(40);
    check("los.hold", 32'(phy_reset), 32'd1);
    tick(7);
    sfp_los = 1'b0;
    tick(5);
    check("los.tail", 32'(phy_reset), 32'd1);
    tick(1);
    check_outs("los.release", 1'b0, 1'b0, 1'b0, 4'd2);
    tick(4);
    check_outs("midreset.pre", 1'b0, 1'b0, 1'b0, 4'd2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("midreset", 1'b1, 1'b0, 1'b0, 4'd0);
    check("midreset.link_drops", 32'(link_drops), 32'd0);

    // ---- Link-up clears a nonzero retry count ----
    do_reset();
    tx_ready = 1'b1;
    rx_ready = 1'b1;
    tick(105);
    check_outs("retryclr.fail", 1'b1, 1'b0, 1'b0, 4'd1);
    rx_syncstatus = 1'b1;
    tick(12);
    check_outs("retryclr.before", 1'b0, 1'b0, 1'b0, 4'd1);
    tick(1);
    check_outs("retryclr.up", 1'b0, 1'b1, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sfp_link_monitor.md
# sfp_link_monitor

Link-level supervisor for the SFP transceiver path, on the same 125 MHz clock as the PHY reset sequencer. It drives the sequencer's `reset` input and consumes its `tx_ready`/`rx_ready`. It waits for word-alignment sync, declares link-up, detects loss of link and re-issues PHY resets. After a bounded number of failed bring-up attempts it latches a fault.

## Interface
- `RESET_CYCLES`, 16: cycles `phy_reset` is held high per reset attempt (minimum 2).
- `READY_TIMEOUT`, 125000: cycles allowed in WAIT_READY (1 ms).
- `SYNC_TIMEOUT`, 125000: cycles allowed in WAIT_SYNC.
- `LOCK_CYCLES`, 8: consecutive `rx_syncstatus` high cycles required to declare link-up.
- `LOSS_CYCLES`, 64: consecutive `rx_syncstatus` low cycles in LINK_UP that declare link loss.
- `MAX_RETRIES`, 15: failed attempts before FAULT (1..15).
- `clk` in 1: 125 MHz clock.
- `reset` in 1: asynchronous, active-high reset.
- `tx_ready` in 1: TX ready from the PHY reset sequencer.
- `rx_ready` in 1: RX ready from the PHY reset sequencer.
- `rx_syncstatus` in 1: word-aligner sync, `clk` domain.
- `sfp_los` in 1: SFP cage loss-of-signal, asynchronous.
- `phy_reset` out 1: drives the sequencer's `reset`.
- `link_up` out 1: link established.
- `link_fault` out 1: sticky fault, retries exhausted.
- `retry_count` out 4: failed attempts since last link-up.
- `link_drops` out 16: count of LINK_UP exits (only with the macro, see Configuration).

## Operation
- States: RESET_PHY, WAIT_READY, WAIT_SYNC, LINK_UP, FAULT.
- On `reset`:
  - state = RESET_PHY, timer = 0, `phy_reset` = 1.
  - `link_up` = 0, `link_fault` = 0, `retry_count` = 0, `link_drops` = 0.
- `sfp_los` passes through a 2-flop synchronizer, giving `los_s`.
- RESET_PHY:
  - `phy_reset` = 1.
  - Timer counts to RESET_CYCLES-1, then go to WAIT_READY.
  - While `los_s` = 1 the timer is held at 0, so the state is held.
- WAIT_READY:
  - `tx_ready` && `rx_ready` → WAIT_SYNC.
  - Timer reaches READY_TIMEOUT-1 → failed attempt.
- WAIT_SYNC:
  - Consecutive-high counter reaches LOCK_CYCLES with `rx_syncstatus` high → LINK_UP.
  - A low sample clears the counter.
  - Timeout at SYNC_TIMEOUT-1 → failed attempt.
  - `rx_ready` low → failed attempt.
- Failed attempt:
  - `retry_count` increments.
  - If the new value equals MAX_RETRIES → FAULT, otherwise → RESET_PHY.
- LINK_UP:
  - On entry, `retry_count` clears.
  - Loss (→ RESET_PHY, not counted as a retry) on any of:
    - `rx_syncstatus` low for LOSS_CYCLES consecutive cycles;
    - `rx_ready` = 0;
    - `los_s` = 1.
  - A single high sample clears the loss counter.
- FAULT:
  - `phy_reset` = 1, `link_fault` = 1, `link_up` = 0.
  - Exit only via `reset`.
- `los_s` = 1 in WAIT_READY or WAIT_SYNC → RESET_PHY with no retry increment.
- Priority within a cycle:
  1. `los_s`
  2. `rx_ready` drop
  3. success condition
  4. timeout
- Timer and counters are unsigned, width `$clog2(max parameter + 1)`. Every state entry clears the timer and counters; they never wrap.

## Timing
- Outputs are registered from next-state. `phy_reset`, `link_up` and `link_fault` change on the same edge the state changes.
- `phy_reset` high pulse is exactly RESET_CYCLES cycles when `los_s` = 0.
- Link-up latency: `link_up` rises on the edge after the LOCK_CYCLES-th consecutive high `rx_syncstatus` sample in WAIT_SYNC.
- Loss latency:
  - `link_up` falls and `phy_reset` rises on the edge after the LOSS_CYCLES-th low sample.
  - For `rx_ready` = 0, this is the edge after the sample.
- `sfp_los` to reaction: 3 edges (2 synchronizer edges + 1 state edge).
- `reset` is asynchronous. Asserting it mid-operation forces all outputs to their reset values immediately.

## Configuration
- `SFP_LINK_MON_STATS_EN` defined:
  - `link_drops` increments on every LINK_UP → RESET_PHY transition, saturating at 16'hFFFF.
  - It clears only on `reset`.
- Undefined: `link_drops` is tied to 0 and no counter logic exists.

## Structure
- Shared package `sfp_pkg` holds:
  - the state enum `link_state_t`;
  - the retry width constant `RETRY_W = 4`.
- Sub-module `sync_2ff` is the generic 2-flop synchronizer for `sfp_los`, reset to 0.
- The FSM, timer and counters live in `sfp_link_monitor`.

## Test plan
Bench parameters: RESET_CYCLES=4, READY_TIMEOUT=100, SYNC_TIMEOUT=100, LOCK_CYCLES=8, LOSS_CYCLES=16, MAX_RETRIES=3.
- Nominal bring-up:
  - Stimulus: release `reset`; raise ready at cycle 10; hold `rx_syncstatus` = 1.
  - Required: `phy_reset` high for 4 cycles; `link_up` = 1 exactly 8 cycles after WAIT_SYNC entry; `retry_count` = 0.
- Sync glitch:
  - Stimulus: in LINK_UP, drop `rx_syncstatus` for 15 cycles.
  - Required: `link_up` stays 1.
  - Stimulus: drop it for 16 cycles.
  - Required: `link_up` → 0 and `phy_reset` → 1 on the next edge; `link_drops` = 1 with the macro, 0 without.
- Ready never arrives:
  - Stimulus: hold `tx_ready` = 0.
  - Required: `retry_count` reads 1, 2, 3 at 104-cycle intervals; then `link_fault` = 1 with `phy_reset` held high until `reset`.
- LOS during bring-up:
  - Stimulus: assert `sfp_los` for 50 cycles in WAIT_SYNC.
  - Required: RESET_PHY 3 edges later; `retry_count` unchanged; `phy_reset` held for the full LOS duration + 4 cycles.
- `rx_ready` drop in LINK_UP:
  - Stimulus: drop `rx_ready` for 1 cycle.
  - Required: `link_up` falls on the next edge; no retry increment.
- Mid-operation reset:
  - Stimulus: assert `reset` in WAIT_SYNC with `retry_count` = 2.
  - Required: all outputs return to reset values without waiting for a clock edge.
